spi_rdid_responder: RTL and testbench
=====================================

Name: spi_rdid_responder

Overview:
- SPI slave (mode 0) that emulates the flash-side response to the RDID instruction.
- Used as the bench/loopback counterpart to the team's SPI master and as an on-FPGA flash stand-in.
- Oversamples SCLK, CS_n and MOSI in the system clk domain and captures an 8-bit opcode. On a match it shifts a fixed 24-bit JEDEC ID out on MISO, MSB first.
- Reports each captured opcode and each completed ID transfer to local logic.

Parameters:
- JEDEC_ID, 24'h20BA18, ID returned MSB first (manufacturer, type, capacity).
- RDID_OPCODE, 8'h9F, opcode that triggers the ID response.
- SYNC_STAGES, 2, flip-flops in each input synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK frequency.
- reset  input  1  synchronous, active-high.
- spi_sclk  input  1  SPI clock from master; idles low (mode 0).
- spi_cs_n  input  1  chip select, active-low.
- spi_mosi  input  1  master-out data, sampled on SCLK rising edge.
- spi_miso  output  1  slave-out data, updated on SCLK falling edge.
- spi_miso_oe  output  1  tri-state enable; 1 only while the ID is being driven.
- cmd_valid  output  1  one-clk pulse when the 8th opcode bit is captured.
- cmd_byte  output  8  last captured opcode; held until the next capture.
- id_done  output  1  one-clk pulse when the 24th ID bit is sampled by the master.
- busy  output  1  1 whenever CS_n is asserted (synchronized value).

Behaviour:
- Reset values:
  - spi_miso=0, spi_miso_oe=0, cmd_valid=0, cmd_byte=8'h00, id_done=0, busy=0.
  - State IDLE; counters and shift registers cleared.
  - Synchronizer flops preset to sclk=0, cs_n=1, mosi=0.
- Synchronization:
  - SCLK, CS_n and MOSI each pass through SYNC_STAGES flops, plus one history flop on SCLK.
  - sclk_rise = sync & ~hist; sclk_fall = ~sync & hist.
  - Latency from a pin edge to internal action: SYNC_STAGES+1 clk.
- States:
  - IDLE: wait for synchronized cs_n=0, then go to CMD with bit_cnt=0. busy=1 from this cycle.
  - CMD:
    - On each sclk_rise, shift mosi into cmd_sr (MSB first) and increment bit_cnt.
    - On the 8th rise: cmd_byte <= full byte and cmd_valid pulses in the same clk.
    - If the byte equals RDID_OPCODE, go to RESP (id_cnt=0, id_sr=JEDEC_ID); otherwise go to IGNORE.
  - RESP:
    - On each sclk_fall: spi_miso_oe=1 and spi_miso=id_sr[23], then shift id_sr left.
    - The first fall after the opcode drives bit 23, so it is valid before the master's first data rising edge.
    - On each sclk_rise, increment id_cnt.
    - On the 24th rise: id_done pulses, id_cnt wraps to 0 and id_sr reloads JEDEC_ID. The ID repeats while CS stays low.
  - IGNORE: MISO not driven; hold until CS deasserts.
- CS deassertion (synchronized cs_n=1), from any state:
  - Next clk: state IDLE, spi_miso_oe=0, spi_miso=0, busy=0, bit_cnt and id_cnt cleared.
  - A partial opcode (<8 bits) produces no cmd_valid.
  - A partial ID produces no id_done.
- Simultaneous events:
  - CS deassert and sclk_rise in the same clk: CS wins and the edge is discarded.
  - Reset has priority over everything.
- Reset mid-transfer returns to IDLE with reset values. A new transfer needs CS_n to be seen high before it is seen low again.
- SCLK edges while CS_n is high are ignored.
- cmd_valid and id_done never assert in the same clk (they are separated by at least one SCLK period).

Decomposition:
- Shared package spi_pkg:
  - RDID opcode constant 8'h9F.
  - Default JEDEC ID.
  - State encoding constants IDLE=2'd0, CMD=2'd1, RESP=2'd2, IGNORE=2'd3, also used for the bench ASCII annotation.
- Sub-module spi_sync_edge:
  - Parameterized N-stage synchronizer with rise/fall detect.
  - Instantiated for SCLK; also for CS_n and MOSI with edge outputs unused.

Test Plan:
- RDID transaction:
  - Stimulus: clk 100 MHz, SCLK 5 MHz; CS low; send 8'h9F, then 24 clocks.
  - Response: cmd_valid once with cmd_byte=9F; master samples 0x20BA18; id_done once; MISO tri-stated within SYNC_STAGES+2 clk of CS high.
- Non-matching opcode:
  - Stimulus: send 8'h05, then 24 clocks.
  - Response: cmd_byte=05; spi_miso_oe stays 0; no id_done; state IGNORE until CS high.
- Continuous read:
  - Stimulus: 9F, then 48 clocks without raising CS.
  - Response: 0x20BA18 received twice; id_done pulses twice, 24 SCLKs apart.
- Abort mid-ID:
  - Stimulus: CS high after 9F plus 10 data clocks, then a new full 9F transaction.
  - Response: no id_done on the aborted transfer; the second transaction returns 0x20BA18 from bit 23.
- Abort mid-opcode:
  - Stimulus: CS high after 5 opcode bits, then 9F.
  - Response: a single cmd_valid (for 9F); the partial bits do not corrupt cmd_byte.
- Reset mid-transfer:
  - Stimulus: assert reset during the ID phase, release, then run a full 9F transaction.
  - Response: all outputs at reset values during reset; the following transaction returns 0x20BA18.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI RDID responder.
package spi_pkg;

    localparam logic [7:0]  RDID_OPCODE_DEFAULT = 8'h9F;
    localparam logic [23:0] JEDEC_ID_DEFAULT    = 24'h20BA18;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned ID_BITS    = 24;
    localparam int unsigned BIT_CNT_W  = 3;
    localparam int unsigned ID_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RESP   = 2'd2,
        IGNORE = 2'd3
    } state_e;

endpackage

// File: rtl/spi_rdid_responder_if.sv
// SPI pin bundle between an SPI master and the RDID responder.
interface spi_rdid_responder_if;

    logic spi_sclk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  spi_miso,
        input  spi_miso_oe
    );

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output spi_miso,
        output spi_miso_oe
    );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage input synchronizer with one history flop for rise/fall detect.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    // Fewer than two stages is not a synchronizer; clamp rather than misbehave.
    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q, sync_d;
    logic         hist_q, hist_d;

    // Shift the pin into the chain; history follows the synchronized output.
    always_comb begin
        sync_d = {sync_q[N-2:0], d};
        hist_d = sync_q[N-1];
    end

    // Chain and history registers, preset to the pin's idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {N{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign q      = sync_q[N-1];
    assign rise_c =  sync_q[N-1] & ~hist_q;
    assign fall_c = ~sync_q[N-1] &  hist_q;

endmodule

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 slave answering the RDID opcode with a fixed JEDEC ID.
module spi_rdid_responder
    import spi_pkg::*;
#(
    parameter logic [23:0] JEDEC_ID    = JEDEC_ID_DEFAULT,
    parameter logic [7:0]  RDID_OPCODE = RDID_OPCODE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_rdid_responder_if.slave  spi,
    output logic                 cmd_valid,
    output logic [7:0]           cmd_byte,
    output logic                 id_done,
    output logic                 busy
);

    logic sclk_s_unused;
    logic sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise_unused, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset  (reset),
        .d      (spi.spi_sclk),
        .q      (sclk_s_unused),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .reset  (reset),
        .d      (spi.spi_cs_n),
        .q      (cs_n_s),
        .rise_c (cs_rise_unused),
        .fall_c (cs_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset  (reset),
        .d      (spi.spi_mosi),
        .q      (mosi_s),
        .rise_c (mosi_rise_unused),
        .fall_c (mosi_fall_unused)
    );

    state_e                state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ID_CNT_W-1:0]   id_cnt_q, id_cnt_d;
    logic [CMD_BITS-1:0]   cmd_sr_q, cmd_sr_d;
    logic [ID_BITS-1:0]    id_sr_q, id_sr_d;
    logic                  miso_q, miso_d;
    logic                  miso_oe_q, miso_oe_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [7:0]            cmd_byte_q, cmd_byte_d;
    logic                  id_done_q, id_done_d;
    logic                  busy_q, busy_d;
    logic                  armed_q, armed_d;
    logic [CMD_BITS-1:0]   cmd_next_c;

    assign cmd_next_c = {cmd_sr_q[CMD_BITS-2:0], mosi_s};

    // Next-state and output logic; CS deassertion overrides any SCLK edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        id_cnt_d    = id_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        id_sr_d     = id_sr_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        cmd_valid_d = 1'b0;
        cmd_byte_d  = cmd_byte_q;
        id_done_d   = 1'b0;
        busy_d      = busy_q;
        // A transfer may only start once CS has been seen high after reset.
        armed_d     = armed_q | cs_n_s;

        if (cs_n_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            id_cnt_d  = '0;
            cmd_sr_d  = '0;
            id_sr_d   = '0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_sr_d  = cmd_next_c;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_CNT_W'(CMD_BITS - 1)) begin
                            cmd_byte_d  = cmd_next_c;
                            cmd_valid_d = 1'b1;
                            id_cnt_d    = '0;
                            id_sr_d     = JEDEC_ID;
                            state_d     = (cmd_next_c == RDID_OPCODE) ? RESP : IGNORE;
                        end
                    end
                end
                RESP: begin
                    if (sclk_fall) begin
                        miso_oe_d = 1'b1;
                        miso_d    = id_sr_q[ID_BITS-1];
                        id_sr_d   = {id_sr_q[ID_BITS-2:0], 1'b0};
                    end else if (sclk_rise) begin
                        if (id_cnt_q == ID_CNT_W'(ID_BITS - 1)) begin
                            id_done_d = 1'b1;
                            id_cnt_d  = '0;
                            id_sr_d   = JEDEC_ID;
                        end else begin
                            id_cnt_d  = id_cnt_q + ID_CNT_W'(1);
                        end
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            id_cnt_q    <= '0;
            cmd_sr_q    <= '0;
            id_sr_q     <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_byte_q  <= 8'h00;
            id_done_q   <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            id_cnt_q    <= id_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            id_sr_q     <= id_sr_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_byte_q  <= cmd_byte_d;
            id_done_q   <= id_done_d;
            busy_q      <= busy_d;
            armed_q     <= armed_d;
        end
    end

    assign spi.spi_miso    = miso_q;
    assign spi.spi_miso_oe = miso_oe_q;
    assign cmd_valid       = cmd_valid_q;
    assign cmd_byte        = cmd_byte_q;
    assign id_done         = id_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Self-checking bench: bit-banged SPI master against a behavioural RDID model.
module tb_spi_rdid_responder;
    import spi_pkg::*;

    localparam int unsigned SYNC = 2;
    localparam logic [23:0] JID  = 24'h20BA18;
    localparam logic [7:0]  RDID = 8'h9F;
    localparam int          HALF = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       id_done;
    logic       busy;

    always #5 clk = ~clk;

    spi_rdid_responder_if spi_if ();

    spi_rdid_responder #(.JEDEC_ID(JID), .RDID_OPCODE(RDID), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .reset     (reset),
        .spi       (spi_if.slave),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .id_done   (id_done),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    int      mon_cmd = 0, mon_id = 0, mon_both = 0, mon_oe = 0;
    longint  cyc = 0, id_prev = 0, id_last = 0;
    logic [7:0] exp_cmd_byte;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid === 1'b1) mon_cmd = mon_cmd + 1;
        if (id_done === 1'b1) begin
            mon_id  = mon_id + 1;
            id_prev = id_last;
            id_last = cyc;
        end
        if (cmd_valid === 1'b1 && id_done === 1'b1) mon_both = mon_both + 1;
        if (spi_if.spi_miso_oe === 1'b1) mon_oe = mon_oe + 1;
    end

    // Reference: data bit i of a continuous read is ID bit 23 - (i mod 24).
    function automatic logic exp_id_bit(input int i);
        logic [23:0] j;
        j = JID;
        return j[23 - (i % 24)];
    endfunction

    function automatic logic [63:0] exp_rx(input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[62:0], exp_id_bit(i)};
        return r;
    endfunction

    // One CS-low frame: op_bits opcode bits MSB first, then data_bits clocks with random MOSI.
    task automatic frame(input logic [7:0] op, input int op_bits, input int data_bits,
                         output logic [63:0] rx, output int oe_low, output int n_resp,
                         output int n_ign, output logic oe_after, output logic busy_after);
        rx = '0; oe_low = 0; n_resp = 0; n_ign = 0;
        spi_if.spi_cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < op_bits; i++) begin
            spi_if.spi_mosi = op[7-i];
            #HALF spi_if.spi_sclk = 1'b1;
            #HALF spi_if.spi_sclk = 1'b0;
        end
        for (int i = 0; i < data_bits; i++) begin
            spi_if.spi_mosi = 1'($urandom);
            #HALF;
            rx = {rx[62:0], spi_if.spi_miso};
            if (spi_if.spi_miso_oe !== 1'b1) oe_low++;
            if (dut.state_q == RESP) n_resp++;
            if (dut.state_q == IGNORE) n_ign++;
            spi_if.spi_sclk = 1'b1;
            #HALF spi_if.spi_sclk = 1'b0;
        end
        #HALF spi_if.spi_cs_n = 1'b1;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        oe_after   = spi_if.spi_miso_oe;
        busy_after = busy;
        #(2*HALF);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        spi_if.spi_sclk = 1'b0; spi_if.spi_cs_n = 1'b1; spi_if.spi_mosi = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({spi_if.spi_miso, spi_if.spi_miso_oe, cmd_valid, cmd_byte, id_done, busy} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got miso=%b oe=%b cv=%b cb=%h idd=%b busy=%b want all 0",
                     spi_if.spi_miso, spi_if.spi_miso_oe, cmd_valid, cmd_byte, id_done, busy);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dut.state_q != IDLE || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got state=%s busy=%b want IDLE 0", dut.state_q.name(), busy);
        end
        exp_cmd_byte = 8'h00;
    endtask

    task automatic test_idle_sclk;
        int c0;
        c0 = mon_cmd;
        for (int i = 0; i < 10; i++) begin
            spi_if.spi_mosi = 1'($urandom);
            #HALF spi_if.spi_sclk = 1'b1;
            #HALF spi_if.spi_sclk = 1'b0;
        end
        checks++;
        if (mon_cmd - c0 != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_sclk got cmds=%0d busy=%b want 0 0", mon_cmd - c0, busy);
        end
    endtask

    task automatic check_rdid(input string nm, input int nd, input int c0, input int i0,
                              input logic [63:0] rx, input int oe_low, input int n_resp,
                              input logic oe_after, input logic busy_after);
        logic [63:0] want;
        logic [63:0] mask;
        want = exp_rx(nd);
        mask = (nd >= 64) ? '1 : ((64'd1 << nd) - 64'd1);
        checks++;
        if (mon_cmd - c0 != 1 || cmd_byte !== RDID) begin
            errors++; $display("FAIL %s_cmd got n=%0d byte=%h want 1 %h", nm, mon_cmd - c0, cmd_byte, RDID);
        end
        checks++;
        if ((rx & mask) !== want) begin
            errors++; $display("FAIL %s_id_data got %h want %h", nm, rx & mask, want);
        end
        checks++;
        if (mon_id - i0 != nd / 24) begin
            errors++; $display("FAIL %s_id_done got %0d want %0d", nm, mon_id - i0, nd / 24);
        end
        checks++;
        if (oe_low != 0 || n_resp != nd) begin
            errors++; $display("FAIL %s_oe_state got oe_low=%0d resp=%0d want 0 %0d", nm, oe_low, n_resp, nd);
        end
        checks++;
        if (oe_after !== 1'b0 || busy_after !== 1'b0) begin
            errors++; $display("FAIL %s_release got oe=%b busy=%b want 0 0", nm, oe_after, busy_after);
        end
    endtask

    task automatic test_rdid;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0; logic oe_a, busy_a;
        c0 = mon_cmd; i0 = mon_id;
        frame(RDID, 8, 24, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        exp_cmd_byte = RDID;
        check_rdid("rdid", 24, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
    endtask

    task automatic test_nomatch;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0, o0; logic oe_a, busy_a;
        c0 = mon_cmd; i0 = mon_id; o0 = mon_oe;
        frame(8'h05, 8, 24, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        exp_cmd_byte = 8'h05;
        checks++;
        if (mon_cmd - c0 != 1 || cmd_byte !== 8'h05) begin
            errors++; $display("FAIL nomatch_cmd got n=%0d byte=%h want 1 05", mon_cmd - c0, cmd_byte);
        end
        checks++;
        if (mon_oe - o0 != 0 || mon_id - i0 != 0) begin
            errors++; $display("FAIL nomatch_quiet got oe_cycles=%0d id_done=%0d want 0 0", mon_oe - o0, mon_id - i0);
        end
        checks++;
        if (n_ign != 24) begin
            errors++; $display("FAIL nomatch_ignore got %0d want 24", n_ign);
        end
    endtask

    task automatic test_continuous;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0; logic oe_a, busy_a;
        c0 = mon_cmd; i0 = mon_id;
        frame(RDID, 8, 48, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        exp_cmd_byte = RDID;
        check_rdid("cont", 48, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
        checks++;
        if (id_last - id_prev != 480) begin
            errors++; $display("FAIL cont_id_spacing got %0d want 480 clk", id_last - id_prev);
        end
    endtask

    task automatic test_abort_id;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0; logic oe_a, busy_a;
        i0 = mon_id;
        frame(RDID, 8, 10, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        checks++;
        if (mon_id - i0 != 0 || rx[9:0] !== exp_rx(10)) begin
            errors++; $display("FAIL abort_id_partial got id_done=%0d bits=%h want 0 %h", mon_id - i0, rx[9:0], exp_rx(10));
        end
        c0 = mon_cmd; i0 = mon_id;
        frame(RDID, 8, 24, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        check_rdid("abort_id_next", 24, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
    endtask

    task automatic test_abort_opcode;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0; logic oe_a, busy_a;
        logic [7:0] junk;
        junk = 8'($urandom);
        c0 = mon_cmd;
        frame(junk, 5, 0, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        checks++;
        if (mon_cmd - c0 != 0 || cmd_byte !== exp_cmd_byte || busy_a !== 1'b0) begin
            errors++; $display("FAIL abort_op_partial got n=%0d byte=%h busy=%b want 0 %h 0",
                               mon_cmd - c0, cmd_byte, busy_a, exp_cmd_byte);
        end
        c0 = mon_cmd; i0 = mon_id;
        frame(RDID, 8, 24, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        exp_cmd_byte = RDID;
        check_rdid("abort_op_next", 24, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
    endtask

    task automatic test_reset_mid;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0; logic oe_a, busy_a;
        logic [7:0] op;
        op = RDID;
        spi_if.spi_cs_n = 1'b0;
        #HALF;
        for (int i = 0; i < 13; i++) begin
            spi_if.spi_mosi = (i < 8) ? op[7-i] : 1'($urandom);
            #HALF spi_if.spi_sclk = 1'b1;
            #HALF spi_if.spi_sclk = 1'b0;
        end
        #30 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_if.spi_miso, spi_if.spi_miso_oe, cmd_valid, cmd_byte, id_done, busy} !== 13'h0
            || dut.state_q != IDLE) begin
            errors++;
            $display("FAIL reset_mid_outputs got miso=%b oe=%b cv=%b cb=%h idd=%b busy=%b state=%s want all 0 IDLE",
                     spi_if.spi_miso, spi_if.spi_miso_oe, cmd_valid, cmd_byte, id_done, busy, dut.state_q.name());
        end
        spi_if.spi_cs_n = 1'b1;
        #HALF reset = 1'b0;
        exp_cmd_byte = 8'h00;
        #(2*HALF);
        c0 = mon_cmd; i0 = mon_id;
        frame(RDID, 8, 24, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
        exp_cmd_byte = RDID;
        check_rdid("reset_mid_next", 24, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
    endtask

    task automatic test_random;
        logic [63:0] rx; int oe_low, n_resp, n_ign, c0, i0, nd; logic oe_a, busy_a;
        logic [7:0] op;
        for (int k = 0; k < 6; k++) begin
            op = ($urandom_range(0, 2) == 0) ? RDID : 8'($urandom);
            nd = $urandom_range(1, 40);
            c0 = mon_cmd; i0 = mon_id;
            frame(op, 8, nd, rx, oe_low, n_resp, n_ign, oe_a, busy_a);
            exp_cmd_byte = op;
            if (op == RDID) begin
                check_rdid("rand_rdid", nd, c0, i0, rx, oe_low, n_resp, oe_a, busy_a);
            end else begin
                checks++;
                if (mon_cmd - c0 != 1 || cmd_byte !== op || mon_id - i0 != 0 || oe_low != nd || n_ign != nd) begin
                    errors++;
                    $display("FAIL rand_other op=%h got n=%0d byte=%h idd=%0d oe_low=%0d ign=%0d want 1 %h 0 %0d %0d",
                             op, mon_cmd - c0, cmd_byte, mon_id - i0, oe_low, n_ign, op, nd, nd);
                end
            end
        end
    endtask

    task automatic test_no_overlap;
        checks++;
        if (mon_both != 0) begin
            errors++; $display("FAIL pulse_overlap got %0d want 0", mon_both);
        end
    endtask

    initial begin
        test_reset();
        test_idle_sclk();
        test_rdid();
        test_nomatch();
        test_continuous();
        test_abort_id();
        test_abort_opcode();
        test_reset_mid();
        test_random();
        test_no_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
